// File: rtl/jk_seq_pkg.sv
// Shared definitions for the JK command sequencer: op encodings, FSM states,
// and the JK next-state function used by the readback model.
package jk_seq_pkg;

  localparam int unsigned OP_W = 2;

  // Command op, bit-for-bit the {j,k} levels it drives
  typedef enum logic [OP_W-1:0] {
    OP_HOLD = 2'b00,
    OP_RST  = 2'b01,
    OP_SET  = 2'b10,
    OP_TGL  = 2'b11
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // JK flip-flop characteristic function
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic nq;
    case (op_e'({j, k}))
      OP_HOLD: nq = q;
      OP_RST:  nq = 1'b0;
      OP_SET:  nq = 1'b1;
      default: nq = ~q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_seq_fifo.sv
// Synchronous command FIFO with registered full/empty flags and level count.
// Ports:
//   clk, rst        clock; synchronous active-low reset (flushes pointers/level)
//   push_i, wr_data_i  write strobe/data (ignored while full)
//   pop_i, rd_data_o   read strobe (ignored while empty) / head entry
//   full_o, empty_o, level_o  occupancy status
module jk_seq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 6,
  parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [W-1:0]     wr_data_i,
  input  logic             pop_i,
  output logic [W-1:0]     rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             full_q;
  logic             empty_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;

  always_comb begin
    level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      full_q  <= (level_d == LVL_W'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  // Storage needs no reset; pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign level_o   = level_q;

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Upstream driver for a JK flip-flop: buffers hold/reset/set/toggle commands
// in a FIFO and replays each as registered {j,k} for max(cnt,1) cycles,
// chaining queued commands without a gap.
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   cmd_valid/cmd_ready      command handshake (ready = FIFO not full)
//   cmd_op, cmd_cnt          op ({j,k} levels) and repeat count
//   j, k                     registered levels to the flip-flop
//   busy                     running or commands queued
//   fifo_level               queued entries
// Optional macro JK_SEQ_READBACK_EN adds q_in/exp_q/mismatch: an internal
// flip-flop model compared against the real q, with a sticky mismatch flag.
module jk_cmd_sequencer
  import jk_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [CNT_W-1:0]             cmd_cnt,
  output logic                         j,
  output logic                         k,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level
`ifdef JK_SEQ_READBACK_EN
  ,
  input  logic                         q_in,
  output logic                         exp_q,
  output logic                         mismatch
`endif
);

  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned FW    = OP_W + CNT_W;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             j_q, j_d;
  logic             k_q, k_d;
  logic             busy_q, busy_d;

  logic             push;
  logic             pop;
  logic [FW-1:0]    head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] level;
  logic [OP_W-1:0]  head_op;
  logic [CNT_W-1:0] head_cnt;
  logic [LVL_W-1:0] level_nxt;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;

  jk_seq_fifo #(
    .DEPTH (DEPTH),
    .W     (FW),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .wr_data_i ({cmd_op, cmd_cnt}),
    .pop_i     (pop),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (level)
  );

  assign head_op  = head[FW-1 -: OP_W];
  // A zero count still runs the command for one cycle
  assign head_cnt = (head[CNT_W-1:0] == '0) ? CNT_W'(1) : head[CNT_W-1:0];

  // Next-state: load from FIFO head when idle or on the last cycle of a run
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    j_d     = j_q;
    k_d     = k_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        j_d = 1'b0;
        k_d = 1'b0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          {j_d, k_d} = head_op;
          rem_d      = head_cnt;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (rem_q <= CNT_W'(1)) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            {j_d, k_d} = head_op;
            rem_d      = head_cnt;
          end else begin
            j_d     = 1'b0;
            k_d     = 1'b0;
            rem_d   = '0;
            state_d = S_IDLE;
          end
        end else begin
          rem_d = rem_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    level_nxt = level + LVL_W'(push) - LVL_W'(pop);
    busy_d    = (state_d == S_RUN) || (level_nxt != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      j_q     <= j_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
    end
  end

  assign j          = j_q;
  assign k          = k_q;
  assign busy       = busy_q;
  assign fifo_level = level;

`ifdef JK_SEQ_READBACK_EN
  logic exp_q_q;
  logic mismatch_q;

  // Shadow flip-flop tracks what the real one should hold; mismatch is sticky
  always_ff @(posedge clk) begin
    if (!rst) begin
      exp_q_q    <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      exp_q_q <= jk_next(exp_q_q, j_q, k_q);
      if (q_in != exp_q_q) mismatch_q <= 1'b1;
    end
  end

  assign exp_q    = exp_q_q;
  assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer (DEPTH=4, CNT_W=4).
module tb_jk_cmd_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned LVL_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic             j;
  logic             k;
  logic             busy;
  logic [LVL_W-1:0] fifo_level;
`ifdef JK_SEQ_READBACK_EN
  logic             q_in;
  logic             exp_q;
  logic             mismatch;
  logic             q_ff;
  logic             force_inv;
`endif

  always #5 clk = ~clk;

  jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_cnt    (cmd_cnt),
    .j          (j),
    .k          (k),
    .busy       (busy),
    .fifo_level (fifo_level)
`ifdef JK_SEQ_READBACK_EN
    ,
    .q_in       (q_in),
    .exp_q      (exp_q),
    .mismatch   (mismatch)
`endif
  );

`ifdef JK_SEQ_READBACK_EN
  // Real flip-flop driven by the sequencer
  always_ff @(posedge clk) begin
    if (!rst) q_ff <= 1'b0;
    else begin
      case ({j, k})
        2'b00:   q_ff <= q_ff;
        2'b01:   q_ff <= 1'b0;
        2'b10:   q_ff <= 1'b1;
        default: q_ff <= ~q_ff;
      endcase
    end
  end
  assign q_in = q_ff ^ force_inv;
`endif

  // exp = {j, k, cmd_ready, fifo_level[2:0], busy} after the edge
  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [1:0] op;
    logic [3:0] cnt;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs [13];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic v, input logic [1:0] op, input logic [3:0] cnt);
    rst       = r;
    cmd_valid = v;
    cmd_op    = op;
    cmd_cnt   = cnt;
  endtask

  function automatic logic [6:0] obs();
    return {j, k, cmd_ready, fifo_level, busy};
  endfunction

  initial begin
    int n;
    drive(1'b0, 1'b1, 2'b10, 4'd3);
`ifdef JK_SEQ_READBACK_EN
    force_inv = 1'b0;
`endif

    // Reset with valid asserted, single run, back-to-back chain
    vecs[0]  = '{1'b0, 1'b1, 2'b10, 4'd3, 7'b0010000};
    vecs[1]  = '{1'b0, 1'b1, 2'b10, 4'd3, 7'b0010000};
    vecs[2]  = '{1'b1, 1'b1, 2'b10, 4'd3, 7'b0010011};
    vecs[3]  = '{1'b1, 1'b0, 2'b00, 4'd0, 7'b1010001};
    vecs[4]  = '{1'b1, 1'b0, 2'b00, 4'd0, 7'b1010001};
    vecs[5]  = '{1'b1, 1'b0, 2'b00, 4'd0, 7'b1010001};
    vecs[6]  = '{1'b1, 1'b0, 2'b00, 4'd0, 7'b0010000};
    vecs[7]  = '{1'b1, 1'b1, 2'b11, 4'd2, 7'b0010011};
    vecs[8]  = '{1'b1, 1'b1, 2'b01, 4'd1, 7'b1110011};
    vecs[9]  = '{1'b1, 1'b1, 2'b10, 4'd0, 7'b1110101};
    vecs[10] = '{1'b1, 1'b0, 2'b00, 4'd0, 7'b0110011};
    vecs[11] = '{1'b1, 1'b0, 2'b00, 4'd0, 7'b1010001};
    vecs[12] = '{1'b1, 1'b0, 2'b00, 4'd0, 7'b0010000};

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].op, vecs[i].cnt);
      tick();
      check($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
    end

    // Fill: first push is popped at once, so the 5th accept fills the FIFO
    drive(1'b0, 1'b0, 2'b00, 4'd0);
    tick();
    drive(1'b1, 1'b1, 2'b11, 4'd15);
    repeat (5) tick();
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_ready", 32'(cmd_ready), 32'd0);
    drive(1'b1, 1'b1, 2'b01, 4'd15);
    repeat (3) tick();
    check("held_off_level", 32'(fifo_level), 32'd4);
    check("held_off_ready", 32'(cmd_ready), 32'd0);
    check("held_off_jk", 32'({j, k}), 32'b11);
    drive(1'b1, 1'b0, 2'b00, 4'd0);
    n = 8;
    while (cmd_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("ready_return_edge", 32'(n), 32'd17);
    check("ready_return_level", 32'(fifo_level), 32'd3);
    check("ready_return_jk", 32'({j, k}), 32'b11);

    // Reset during a run with two entries queued
    drive(1'b0, 1'b0, 2'b00, 4'd0);
    tick();
    check("pre5_reset", 32'(obs()), 32'b0010000);
    drive(1'b1, 1'b1, 2'b11, 4'd10);
    tick();
    drive(1'b1, 1'b1, 2'b01, 4'd5);
    tick();
    drive(1'b1, 1'b1, 2'b10, 4'd5);
    tick();
    drive(1'b1, 1'b0, 2'b00, 4'd0);
    tick();
    check("run_two_queued", 32'(obs()), 32'b1110101);
    drive(1'b0, 1'b0, 2'b00, 4'd0);
    tick();
    check("abort_reset", 32'(obs()), 32'b0010000);
    drive(1'b1, 1'b0, 2'b00, 4'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("no_replay%0d", i), 32'(obs()), 32'b0010000);
    end

`ifdef JK_SEQ_READBACK_EN
    drive(1'b1, 1'b1, 2'b11, 4'd3);
    tick();
    drive(1'b1, 1'b1, 2'b10, 4'd2);
    tick();
    drive(1'b1, 1'b1, 2'b11, 4'd1);
    tick();
    drive(1'b1, 1'b0, 2'b00, 4'd0);
    repeat (8) tick();
    check("rb_exp_q", 32'(exp_q), 32'(q_ff));
    check("rb_clean", 32'(mismatch), 32'd0);
    force_inv = 1'b1;
    tick();
    force_inv = 1'b0;
    check("rb_set", 32'(mismatch), 32'd1);
    repeat (3) tick();
    check("rb_sticky", 32'(mismatch), 32'd1);
    drive(1'b0, 1'b0, 2'b00, 4'd0);
    tick();
    check("rb_reset", 32'(mismatch), 32'd0);
    drive(1'b1, 1'b0, 2'b00, 4'd0);
    repeat (3) tick();
    check("rb_after", 32'(mismatch), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
